// File: rtl/ah_snoop_arb_pkg.sv
// ah_snoop_arb_pkg: shared types and defaults for the snoop FIFO arbiter.
// Contents:
//   state_e         FSM state encoding (IDLE, SNOOP, WRITE, DROP)
//   DEF_DATA_W      default word width
//   DEF_NUM_REQ     default requester count
//   DEF_DEPTH       default FIFO depth / initial credit count
//   idx_w()         width of a requester index
package ah_snoop_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SNOOP = 2'd1,
        ST_WRITE = 2'd2,
        ST_DROP  = 2'd3
    } state_e;

    localparam int DEF_DATA_W  = 10;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DEPTH   = 16;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ah_rr_arbiter.sv
// ah_rr_arbiter: combinational round-robin grant.
// Ports:
//   req_i   request vector, one bit per requester
//   ptr_i   highest-priority requester; priority ascends from here with wrap
//   gnt_o   one-hot grant (zero when nobody requests)
//   idx_o   index of the granted requester
//   any_o   1 when some requester is granted
module ah_rr_arbiter
    import ah_snoop_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ah_snoop_fifo_arbiter.sv
// ah_snoop_fifo_arbiter: round-robin, credit-controlled writer into a snoopable FIFO
// with optional duplicate dropping.
// Ports:
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   req_valid_i/req_data_i per-requester request and word (requester i at [i*DATA_W +: DATA_W])
//   req_ack_o              one-cycle pulse: word written to the FIFO
//   req_drop_o             one-cycle pulse: word discarded as a duplicate
//   dedup_en_i             enables duplicate dropping
//   fifo_wr_data_o/valid_o FIFO write port
//   fifo_wr_credit_i       one pulse per freed FIFO slot
//   fifo_snoop_data_o/valid_o, fifo_snoop_match_i  snoop handshake (match is same-cycle)
//   credits_o              current free-slot count
//   busy_o                 1 while a request is in flight
//   err_o                  sticky credit-overflow flag
module ah_snoop_fifo_arbiter
    import ah_snoop_arb_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int CNT_W   = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ack_o,
    output logic [NUM_REQ-1:0]        req_drop_o,
    input  logic                      dedup_en_i,
    output logic [DATA_W-1:0]         fifo_wr_data_o,
    output logic                      fifo_wr_valid_o,
    input  logic                      fifo_wr_credit_i,
    output logic [DATA_W-1:0]         fifo_snoop_data_o,
    output logic                      fifo_snoop_valid_o,
    input  logic                      fifo_snoop_match_i,
    output logic [CNT_W-1:0]          credits_o,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int               IDX_W = idx_w(NUM_REQ);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    state_e             state_q;
    logic [IDX_W-1:0]   rr_ptr_q, win_q, arb_idx, next_ptr;
    logic [NUM_REQ-1:0] win_oh_q, arb_gnt, ack_q, drop_q;
    logic               arb_any, wr_valid_q, snoop_valid_q, busy_q, can_wr;
    logic [DATA_W-1:0]  data_q;
    logic [CNT_W-1:0]   credits_q, credits_d;
    logic               err_q, err_d;

    ah_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // A write and a returned credit in the same cycle cancel; a credit with the
    // counter already full is dropped and flagged.
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        if (wr_valid_q && !fifo_wr_credit_i)
            credits_d = credits_q - CNT_W'(1);
        else if (!wr_valid_q && fifo_wr_credit_i) begin
            if (credits_q == FULL)
                err_d = 1'b1;
            else
                credits_d = credits_q + CNT_W'(1);
        end
    end

    // Strobes are registered, so the write for the next cycle is decided against
    // the count that will be visible in that cycle.
    assign can_wr   = (credits_d != '0);
    assign next_ptr = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            win_q         <= '0;
            win_oh_q      <= '0;
            data_q        <= '0;
            ack_q         <= '0;
            drop_q        <= '0;
            wr_valid_q    <= 1'b0;
            snoop_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            credits_q     <= FULL;
            err_q         <= 1'b0;
        end else begin
            credits_q     <= credits_d;
            err_q         <= err_d;
            ack_q         <= '0;
            drop_q        <= '0;
            wr_valid_q    <= 1'b0;
            snoop_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        win_q         <= arb_idx;
                        win_oh_q      <= arb_gnt;
                        data_q        <= req_data_i[arb_idx*DATA_W +: DATA_W];
                        snoop_valid_q <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= ST_SNOOP;
                    end
                end
                ST_SNOOP: begin
                    if (dedup_en_i && fifo_snoop_match_i) begin
                        drop_q  <= win_oh_q;
                        state_q <= ST_DROP;
                    end else begin
                        wr_valid_q <= can_wr;
                        ack_q      <= can_wr ? win_oh_q : '0;
                        state_q    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (wr_valid_q) begin
                        rr_ptr_q <= next_ptr;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else begin
                        wr_valid_q <= can_wr;
                        ack_q      <= can_wr ? win_oh_q : '0;
                    end
                end
                ST_DROP: begin
                    rr_ptr_q <= next_ptr;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ack_o          = ack_q;
    assign req_drop_o         = drop_q;
    assign fifo_wr_valid_o    = wr_valid_q;
    assign fifo_wr_data_o     = data_q;
    assign fifo_snoop_valid_o = snoop_valid_q;
    assign fifo_snoop_data_o  = data_q;
    assign credits_o          = credits_q;
    assign busy_o             = busy_q;
    assign err_o              = err_q;

endmodule

// File: tb/tb_ah_snoop_fifo_arbiter.sv
// tb_ah_snoop_fifo_arbiter: randomized bench with a transaction-level reference model;
// the bench also plays the requesters and the snoopable FIFO.
module tb_ah_snoop_fifo_arbiter;

    localparam int DATA_W  = 10;
    localparam int NUM_REQ = 4;
    localparam int DEPTH   = 16;
    localparam int CNT_W   = 5;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_ack, req_drop;
    logic                      dedup_en = 1'b0;
    logic [DATA_W-1:0]         fifo_wr_data, fifo_snoop_data;
    logic                      fifo_wr_valid, fifo_snoop_valid;
    logic                      fifo_wr_credit = 1'b0;
    logic                      fifo_snoop_match = 1'b0;
    logic [CNT_W-1:0]          credits;
    logic                      busy, err;

    always #5 clk = ~clk;

    ah_snoop_fifo_arbiter #(
        .DATA_W (DATA_W), .NUM_REQ (NUM_REQ), .DEPTH (DEPTH), .CNT_W (CNT_W)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .req_valid_i        (req_valid),
        .req_data_i         (req_data),
        .req_ack_o          (req_ack),
        .req_drop_o         (req_drop),
        .dedup_en_i         (dedup_en),
        .fifo_wr_data_o     (fifo_wr_data),
        .fifo_wr_valid_o    (fifo_wr_valid),
        .fifo_wr_credit_i   (fifo_wr_credit),
        .fifo_snoop_data_o  (fifo_snoop_data),
        .fifo_snoop_valid_o (fifo_snoop_valid),
        .fifo_snoop_match_i (fifo_snoop_match),
        .credits_o          (credits),
        .busy_o             (busy),
        .err_o              (err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // stimulus state: requesters and the FIFO the bench stands in for
    bit                rq_pend[NUM_REQ];
    logic [DATA_W-1:0] rq_word[NUM_REQ];
    logic [DATA_W-1:0] fifo_q[$];
    int                gen_rate = 0, pop_rate = 0;
    bit                force_cr = 0, dedup = 0;

    // reference model: one in-flight transaction plus credit bookkeeping
    bit                m_active, m_dup, m_err;
    int                m_win, m_t, m_ptr, m_cred;
    logic [DATA_W-1:0] m_word;
    // expected outputs for the cycle the next step() samples
    logic [NUM_REQ-1:0] x_ack, x_drop;
    bit                 x_wr, x_snoop, x_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit resident(input logic [DATA_W-1:0] w);
        foreach (fifo_q[i]) if (fifo_q[i] == w) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_active = 0; m_dup = 0; m_err = 0; m_ptr = 0; m_cred = DEPTH;
        x_ack = '0; x_drop = '0; x_wr = 0; x_snoop = 0; x_busy = 0;
        fifo_q.delete();
    endtask

    // called mid-cycle: check this cycle, drive inputs for it, predict the next one
    task automatic step();
        bit cr;
        bit found;
        int n_cred, i;
        logic [NUM_REQ-1:0] nx_ack, nx_drop;
        bit nx_wr, nx_snoop;
        check("ack", req_ack, x_ack);
        check("drop", req_drop, x_drop);
        check("wr_valid", fifo_wr_valid, x_wr);
        if (x_wr) check("wr_data", fifo_wr_data, m_word);
        check("snoop_valid", fifo_snoop_valid, x_snoop);
        if (x_snoop) check("snoop_data", fifo_snoop_data, m_word);
        check("credits", credits, m_cred);
        check("busy", busy, x_busy);
        check("err", err, m_err);
        for (int r = 0; r < NUM_REQ; r++) begin
            if (x_ack[r] || x_drop[r]) rq_pend[r] = 0;
            if (!rq_pend[r] && $urandom_range(99) < gen_rate) begin
                rq_pend[r] = 1;
                rq_word[r] = DATA_W'($urandom_range(15));
            end
        end
        cr = 0;
        if (force_cr || (fifo_q.size() > 0 && $urandom_range(99) < pop_rate)) begin
            cr = 1;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        force_cr = 0;
        fifo_snoop_match = fifo_snoop_valid && resident(fifo_snoop_data);
        for (int r = 0; r < NUM_REQ; r++) begin
            req_valid[r] = rq_pend[r];
            req_data[r*DATA_W +: DATA_W] = rq_word[r];
        end
        fifo_wr_credit = cr;
        dedup_en = dedup;
        // model: credits move by writes and returns, clamped at DEPTH with a sticky error
        n_cred = m_cred - int'(x_wr) + int'(cr);
        if (n_cred > DEPTH) begin
            n_cred = DEPTH;
            m_err = 1;
        end
        nx_ack = '0; nx_drop = '0; nx_wr = 0; nx_snoop = 0;
        if (!m_active) begin
            found = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
                i = (m_ptr + k) % NUM_REQ;
                if (!found && rq_pend[i]) begin
                    found = 1; m_win = i; m_word = rq_word[i]; m_t = cyc; m_active = 1; nx_snoop = 1;
                end
            end
        end else if (x_ack != 0 || x_drop != 0) begin
            m_active = 0;
            m_ptr = (m_win + 1) % NUM_REQ;
        end else begin
            if (cyc == m_t + 1) m_dup = dedup && resident(m_word);
            if (m_dup) nx_drop[m_win] = 1'b1;
            else if (n_cred > 0) begin
                nx_ack[m_win] = 1'b1;
                nx_wr = 1;
            end
        end
        if (x_wr) fifo_q.push_back(m_word);
        m_cred = n_cred;
        x_ack = nx_ack; x_drop = nx_drop; x_wr = nx_wr; x_snoop = nx_snoop; x_busy = m_active;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            step();
        end
    endtask

    task automatic drain();
        bit pend;
        for (int i = 0; i < 300; i++) begin
            pend = m_active;
            foreach (rq_pend[r]) pend |= rq_pend[r];
            if (!pend) return;
            run(1);
        end
        check("drain_timeout", 1, 0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        req_valid = '0; fifo_wr_credit = 0; fifo_snoop_match = 0;
        repeat (3) @(negedge clk);
        model_reset();
        rst_n = 1;
    endtask

    initial begin
        foreach (rq_pend[r]) begin
            rq_pend[r] = 0;
            rq_word[r] = '0;
        end
        do_reset();
        run(2);
        // single request from requester 2
        rq_pend[2] = 1; rq_word[2] = 10'h155;
        run(6);
        // fairness with all requesters continuously valid
        gen_rate = 100;
        run(16);
        gen_rate = 0;
        drain();
        // duplicate: write 0A3, then offer it again with dedup enabled
        dedup = 1;
        rq_pend[0] = 1; rq_word[0] = 10'h0A3;
        drain();
        rq_pend[1] = 1; rq_word[1] = 10'h0A3;
        drain();
        // credit exhaustion and recovery
        dedup = 0; gen_rate = 100; pop_rate = 0;
        run(60);
        pop_rate = 30;
        run(40);
        // empty the FIFO, then return one credit too many
        gen_rate = 0; pop_rate = 100;
        drain();
        for (int i = 0; i < 40 && fifo_q.size() > 0; i++) run(1);
        force_cr = 1;
        run(3);
        // randomized traffic
        for (int p = 0; p < 12; p++) begin
            dedup = $urandom_range(1);
            gen_rate = $urandom_range(10, 90);
            pop_rate = $urandom_range(5, 70);
            run(50);
        end
        // reset while a snoop is in progress
        gen_rate = 60; pop_rate = 20;
        for (int i = 0; i < 50 && !x_snoop; i++) run(1);
        if (!x_snoop) check("snoop_wait", 0, 1);
        @(posedge clk);
        #2;
        do_reset();
        gen_rate = 0; pop_rate = 0;
        foreach (rq_pend[r]) rq_pend[r] = 1;
        run(14);
        drain();
        run(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ah_snoop_fifo_arbiter.md
# ah_snoop_fifo_arbiter

Shares one snoopable FIFO write port between NUM_REQ requesters using round-robin arbitration and credit-based flow control. Before each write, the arbiter snoops the FIFO for the candidate word. When de-duplication is enabled, it drops words already resident in the FIFO. It sits directly in front of the snoopable FIFO's wr_valid/wr_credit/snoop_* ports; the FIFO read side is untouched.

## Interface
- DATA_W, 10: word width; equals the FIFO width
- NUM_REQ, 4: number of requesters, 2..8
- DEPTH, 16: FIFO depth; initial credit count
- CNT_W, 5: credit counter width; must hold DEPTH
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester request; held with req_data until ack or drop
- req_data  in  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W]
- req_ack  out  NUM_REQ  one-cycle pulse: the word was written to the FIFO
- req_drop  out  NUM_REQ  one-cycle pulse: the word was discarded as a duplicate
- dedup_en  in  1  quasi-static; 1 enables duplicate dropping
- fifo_wr_data  out  DATA_W  word to the FIFO
- fifo_wr_valid  out  1  one-cycle write strobe
- fifo_wr_credit  in  1  one pulse per freed FIFO slot
- fifo_snoop_data  out  DATA_W  compare word
- fifo_snoop_valid  out  1  snoop qualifier
- fifo_snoop_match  in  1  combinational match from the FIFO, same cycle
- credits  out  CNT_W  current free-slot count
- busy  out  1  1 when the FSM is not in IDLE
- err  out  1  sticky; set on credit overflow

## Operation
- FSM states are IDLE, SNOOP, WRITE and DROP.
- IDLE:
  - If any req_valid is high, select the winner by round-robin.
  - Priority starts at rr_ptr and ascends with wrap-around.
  - Latch the winner index and its data, then go to SNOOP.
- SNOOP:
  - Drive fifo_snoop_valid=1 and fifo_snoop_data=latched word.
  - Register dup = dedup_en & fifo_snoop_match.
  - If dup, go to DROP; otherwise go to WRITE.
  - The SNOOP cycle is always taken, so latency is fixed regardless of dedup_en.
- WRITE:
  - If credits>0: fifo_wr_valid=1, fifo_wr_data=latched word, req_ack[winner]=1; then rr_ptr=winner+1 (mod NUM_REQ) and go to IDLE.
  - If credits==0: stay in WRITE with all strobes low.
- DROP:
  - req_drop[winner]=1, rr_ptr=winner+1 (mod NUM_REQ), go to IDLE.
  - No FIFO write and no credit change.
- Credit counter:
  - Resets to DEPTH.
  - Decrements on a write and increments on fifo_wr_credit.
  - A write and a credit in the same cycle leave it unchanged.
  - A credit arriving while the count equals DEPTH without a write is an overflow: the count saturates at DEPTH and err is set.
- A req_valid deassertion by the winner before its ack or drop is a protocol violation. The latched word is still written or dropped.
- An entry popped between SNOOP and WRITE can cause a dropped word to no longer be resident. This is accepted behaviour; the snoop is advisory.

## Timing
- Reset values: all outputs 0 except credits=DEPTH; state IDLE, rr_ptr=0, err=0.
- Latency: req_valid seen in IDLE at cycle t produces the snoop at t+1 and ack or drop at t+2 when credits>0.
- Each stalled cycle at credits==0 adds one cycle.
- Throughput is one request per 3 cycles.
- ack and drop are mutually exclusive and never repeated for the same latch.
- fifo_wr_valid and req_ack are asserted in the same cycle.
- rstn asserted mid-operation:
  - The in-flight request is abandoned with no ack.
  - Credits return to DEPTH; the FIFO is reset by the same rstn.

## Structure
- Package ah_snoop_arb_pkg holds:
  - the FSM state enum (2 bits)
  - the default localparams for DATA_W, NUM_REQ and DEPTH
- Sub-module ah_rr_arbiter:
  - NUM_REQ-wide combinational round-robin grant, given the request vector and rr_ptr
  - outputs a one-hot grant and the winner index

## Test plan
- Single request, dedup_en=0: requester 2 sends 10'h155. Snoop at t+1; fifo_wr_valid and req_ack[2] at t+2; credits 16→15.
- Fairness: all 4 requesters held valid. Acks occur in order 0,1,2,3,0, spaced 3 cycles apart.
- Duplicate: 10'h0A3 is resident, dedup_en=1, requester 1 sends 10'h0A3. req_drop[1] at t+2; no write; credits unchanged.
- Credit exhaustion:
  - 16 writes with no credits returned leave credits=0; the 17th request stalls in WRITE with busy=1.
  - One fifo_wr_credit pulse produces the write on the next cycle.
- Simultaneous write and credit in the same cycle: credits hold steady. An extra credit at credits=16 sets err=1 and credits stays 16.
- Reset during SNOOP: no ack or drop is issued; after release, credits=16, state is IDLE and rr_ptr=0.
